mac_array_seq: RTL

MAC_ARRAY_SEQ -- requirements
Module: mac_array_seq

---
 rtl/mac_array_seq.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mac_array_seq.sv
// mac_array_seq -- sequencer for a row x col array of mac_tiles.
//
// One operation starts on an accepted start pulse in IDLE. Weight-stationary
// (WS) runs LOAD -> GAP -> EXEC -> DRAIN -> DONE. Output-stationary (OS) runs
// EXEC -> FLUSH -> DRAIN -> DONE.
//
// Configuration macro: MAC_ARRAY_SEQ_OS_EN
//   defined   : OS operation is available and selected by os_mode.
//   undefined : os_mode is ignored, FLUSH does not exist, inst_w[2] is 0.
//
// Ports
//   clk       in   single clock, all state on posedge
//   reset     in   synchronous active-high reset
//   start     in   begin one tile operation (accepted only in IDLE)
//   os_mode   in   1 = OS, 0 = WS, sampled when start is accepted
//   k_len     in   number of execute vectors, sampled when start is accepted
//   l0_ready  in   input buffer holds at least one vector
//   l0_rd     out  pop one vector from the input buffer this cycle
//   inst_w    out  [2] OS mode, [1] execute, [0] kernel load (WS) / flush (OS)
//   busy      out  operation in progress (every state except IDLE)
//   done      out  one-cycle completion pulse
module mac_array_seq #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              os_mode,
  input  logic [len_bw-1:0] k_len,
  input  logic              l0_ready,
  output logic              l0_rd,
  output logic [2:0]        inst_w,
  output logic              busy,
  output logic              done
);

  localparam int drain_len = row + col - 1;
  localparam int kmax      = (2 ** len_bw) - 1;
  localparam int cmax_a    = (kmax > drain_len) ? kmax : drain_len;
  localparam int cmax      = (cmax_a > col) ? cmax_a : col;
  // Wide enough that count + 1 never wraps for any phase length.
  localparam int cw        = $clog2(cmax + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_EXEC,
`ifdef MAC_ARRAY_SEQ_OS_EN
    S_FLUSH,
`endif
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [cw-1:0]     cnt_reg, cnt_next;
  logic [len_bw-1:0] klen_reg, klen_next;
  logic              os_eff;

`ifdef MAC_ARRAY_SEQ_OS_EN
  logic os_reg, os_next;
  assign os_eff = os_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      os_reg <= 1'b0;
    end else begin
      os_reg <= os_next;
    end
  end
`else
  // Without OS support the mode input has no effect on anything.
  logic os_unused;
  assign os_unused = os_mode;
  assign os_eff    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      klen_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      klen_reg  <= klen_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    klen_next  = klen_reg;
`ifdef MAC_ARRAY_SEQ_OS_EN
    os_next    = os_reg;
`endif
    inst_w     = 3'b000;
    l0_rd      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          klen_next  = k_len;
          cnt_next   = '0;
          state_next = S_LOAD;
`ifdef MAC_ARRAY_SEQ_OS_EN
          os_next = os_mode;
          // OS skips loading; a zero-length EXEC falls straight to FLUSH.
          if (os_mode) begin
            state_next = (k_len == '0) ? S_FLUSH : S_EXEC;
          end
`endif
        end
      end

      S_LOAD: begin
        // Loads stall (no pop, no instruction) while the buffer is empty.
        if (l0_ready) begin
          inst_w = 3'b001;
          l0_rd  = 1'b1;
          if (cnt_reg == cw'(col - 1)) begin
            cnt_next   = '0;
            state_next = S_GAP;
          end else begin
            cnt_next = cnt_reg + cw'(1);
          end
        end
      end

      S_GAP: begin
        cnt_next   = '0;
        state_next = (klen_reg == '0) ? S_DRAIN : S_EXEC;
      end

      S_EXEC: begin
        inst_w = {os_eff, 2'b00};
        if (l0_ready) begin
          inst_w = {os_eff, 2'b10};
          l0_rd  = 1'b1;
          if ((cnt_reg + cw'(1)) == cw'(klen_reg)) begin
            cnt_next   = '0;
            state_next = S_DRAIN;
`ifdef MAC_ARRAY_SEQ_OS_EN
            if (os_reg) begin
              state_next = S_FLUSH;
            end
`endif
          end else begin
            cnt_next = cnt_reg + cw'(1);
          end
        end
      end

`ifdef MAC_ARRAY_SEQ_OS_EN
      S_FLUSH: begin
        // Fixed length, never stalls: no buffer reads are involved.
        inst_w = 3'b101;
        if (cnt_reg == cw'(row - 1)) begin
          cnt_next   = '0;
          state_next = S_DRAIN;
        end else begin
          cnt_next = cnt_reg + cw'(1);
        end
      end
`endif

      S_DRAIN: begin
        inst_w = {os_eff, 2'b00};
        if (cnt_reg == cw'(drain_len - 1)) begin
          cnt_next   = '0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_reg + cw'(1);
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule
